// File: rtl/gs_pipe_ctrl.sv
// rtl/gs_pipe_ctrl.sv - hazard, stall, flush and debug-halt sequencing for the 5-stage GS pipeline
module gs_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_MemRead_i,
  input  logic             ex_MemWrite_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic [1:0]       ex_PCSrc_i,
  input  logic             ex_br_taken_i,
  input  logic [31:0]      ex_br_addr_i,
  input  logic [31:0]      ex_uncod_jump_addr_i,
  input  logic             lsu_ready_i,
  input  logic             dbg_halt_req_i,
  input  logic             dbg_resume_i,
  input  logic             cnt_clr_i,
  output logic             halt_if_o,
  output logic             halt_id_o,
  output logic             halt_ex_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_addr_o,
  output logic             dbg_halted_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DBG_HALT} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic             mem_err_q, err_set;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_ev, redir_ev, lu_ev;

  assign mem_ev   = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i);
  assign redir_ev = ex_valid_i & (((ex_PCSrc_i == 2'b01) & ex_br_taken_i) | (ex_PCSrc_i == 2'b10));
  assign lu_ev    = ex_valid_i & ex_MemRead_i & (ex_rd_addr_i != 5'd0) & id_valid_i &
                    ((ex_rd_addr_i == id_rs1_addr_i) |
                     (id_uses_rs2_i & (ex_rd_addr_i == id_rs2_addr_i)));

  always_comb begin
    state_n         = state;
    timer_n         = timer;
    err_set         = 1'b0;
    halt_if_o       = 1'b0;
    halt_id_o       = 1'b0;
    halt_ex_o       = 1'b0;
    flush_id_o      = 1'b0;
    flush_ex_o      = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = 32'd0;
    dbg_halted_o    = 1'b0;
    case (state)
      RUN: begin
        if (mem_ev && !lsu_ready_i) begin
          halt_if_o = 1'b1;
          halt_id_o = 1'b1;
          halt_ex_o = 1'b1;
          state_n   = MEM_WAIT;
          timer_n   = '0;
        end else if (redir_ev) begin
          // ID holds a wrong-path instruction, so any load-use match there is moot
          redirect_o      = 1'b1;
          flush_id_o      = 1'b1;
          flush_ex_o      = 1'b1;
          redirect_addr_o = (ex_PCSrc_i == 2'b01) ? ex_br_addr_i : ex_uncod_jump_addr_i;
        end else if (lu_ev) begin
          halt_if_o  = 1'b1;
          halt_id_o  = 1'b1;
          flush_ex_o = 1'b1;
        end else if (dbg_halt_req_i) begin
          state_n = DBG_HALT;
        end
      end
      MEM_WAIT: begin
        if (lsu_ready_i) begin
          state_n = RUN;
        end else if (timer == TIMER_LAST) begin
          // abandon the stuck access: bubble EX and let the rest of the pipe resume
          halt_if_o  = 1'b1;
          halt_id_o  = 1'b1;
          flush_ex_o = 1'b1;
          err_set    = 1'b1;
          state_n    = RUN;
        end else begin
          halt_if_o = 1'b1;
          halt_id_o = 1'b1;
          halt_ex_o = 1'b1;
          timer_n   = timer + 1'b1;
        end
      end
      DBG_HALT: begin
        if (dbg_resume_i) begin
          state_n = RUN;
        end else begin
          halt_if_o    = 1'b1;
          halt_id_o    = 1'b1;
          halt_ex_o    = 1'b1;
          dbg_halted_o = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
    if (rst) begin
      state_n         = RUN;
      err_set         = 1'b0;
      halt_if_o       = 1'b0;
      halt_id_o       = 1'b0;
      halt_ex_o       = 1'b0;
      flush_id_o      = 1'b0;
      flush_ex_o      = 1'b0;
      redirect_o      = 1'b0;
      redirect_addr_o = 32'd0;
      dbg_halted_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      timer     <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      mem_err_q <= mem_err_q | err_set;
      if (cnt_clr_i)
        stall_cnt <= '0;
      else if (halt_if_o && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (cnt_clr_i)
        flush_cnt <= '0;
      else if (redirect_o && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign mem_err_o   = mem_err_q & ~rst;
  assign stall_cnt_o = rst ? '0 : stall_cnt;
  assign flush_cnt_o = rst ? '0 : flush_cnt;

endmodule

// File: tb/tb_gs_pipe_ctrl.sv
// tb/tb_gs_pipe_ctrl.sv - directed scoreboard bench for gs_pipe_ctrl
module tb_gs_pipe_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic        clk = 1'b1;
  logic        rst;
  logic        id_valid_i, id_uses_rs2_i, ex_valid_i, ex_MemRead_i, ex_MemWrite_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic [1:0]  ex_PCSrc_i;
  logic        ex_br_taken_i, lsu_ready_i, dbg_halt_req_i, dbg_resume_i, cnt_clr_i;
  logic [31:0] ex_br_addr_i, ex_uncod_jump_addr_i;
  logic        halt_if_o, halt_id_o, halt_ex_o, flush_id_o, flush_ex_o, redirect_o;
  logic        dbg_halted_o, mem_err_o;
  logic [31:0] redirect_addr_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  gs_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_valid_i(ex_valid_i), .ex_MemRead_i(ex_MemRead_i),
    .ex_MemWrite_i(ex_MemWrite_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_PCSrc_i(ex_PCSrc_i),
    .ex_br_taken_i(ex_br_taken_i), .ex_br_addr_i(ex_br_addr_i),
    .ex_uncod_jump_addr_i(ex_uncod_jump_addr_i), .lsu_ready_i(lsu_ready_i),
    .dbg_halt_req_i(dbg_halt_req_i), .dbg_resume_i(dbg_resume_i), .cnt_clr_i(cnt_clr_i),
    .halt_if_o(halt_if_o), .halt_id_o(halt_id_o), .halt_ex_o(halt_ex_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .redirect_o(redirect_o),
    .redirect_addr_o(redirect_addr_o), .dbg_halted_o(dbg_halted_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [7:0]  ctrl;   // halt_if,halt_id,halt_ex,flush_id,flush_ex,redirect,dbg_halted,mem_err
    logic [31:0] addr;
    logic [7:0]  cnts;   // stall,flush
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_stall = 0, exp_flush = 0;
  logic exp_err = 1'b0;

  // compare combinational outputs mid-cycle, on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act_c;
      e = exp_q.pop_front();
      act_c = {halt_if_o, halt_id_o, halt_ex_o, flush_id_o, flush_ex_o, redirect_o,
               dbg_halted_o, mem_err_o};
      tests++;
      assert (act_c === e.ctrl) else begin
        fails++;
        $error("FAIL %s ctrl observed=%b expected=%b", e.tag, act_c, e.ctrl);
      end
      tests++;
      assert (redirect_addr_o === e.addr) else begin
        fails++;
        $error("FAIL %s addr observed=%h expected=%h", e.tag, redirect_addr_o, e.addr);
      end
      tests++;
      assert ({stall_cnt_o, flush_cnt_o} === e.cnts) else begin
        fails++;
        $error("FAIL %s counters observed=%h expected=%h", e.tag, {stall_cnt_o, flush_cnt_o}, e.cnts);
      end
    end
  end

  task automatic idle();
    id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_uses_rs2_i = 0;
    ex_valid_i = 0; ex_MemRead_i = 0; ex_MemWrite_i = 0; ex_rd_addr_i = 0;
    ex_PCSrc_i = 0; ex_br_taken_i = 0; ex_br_addr_i = 32'h0000_0200;
    ex_uncod_jump_addr_i = 32'hDEAD_BEE0; lsu_ready_i = 1; dbg_halt_req_i = 0;
    dbg_resume_i = 0; cnt_clr_i = 0;
  endtask

  // c = {halt_if,halt_id,halt_ex,flush_id,flush_ex,redirect,dbg_halted}
  task automatic step(input string tag, input logic [6:0] c, input logic [31:0] a);
    exp_t e;
    e.tag = tag;
    if (rst) begin
      e.ctrl = 8'd0; e.addr = 32'd0; e.cnts = 8'd0;
    end else begin
      e.ctrl = {c, exp_err}; e.addr = a;
      e.cnts = {4'(exp_stall), 4'(exp_flush)};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_stall = 0; exp_flush = 0; exp_err = 1'b0;
    end else if (cnt_clr_i) begin
      exp_stall = 0; exp_flush = 0;
    end else begin
      if (c[6] && exp_stall < CNT_MAX) exp_stall++;
      if (c[1] && exp_flush < CNT_MAX) exp_flush++;
    end
  endtask

  initial begin
    idle();
    rst = 1;
    ex_valid_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 5; id_valid_i = 1; id_rs1_addr_i = 5;
    step("reset_gated", 7'b0, 0);
    rst = 0; idle();
    step("post_reset_idle", 7'b0, 0);

    // load-use on rs1, then the load has moved on
    ex_valid_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 5; id_valid_i = 1; id_rs1_addr_i = 5;
    step("lu_rs1", 7'b1100100, 0);
    idle();
    step("lu_cleared", 7'b0, 0);
    ex_valid_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 0; id_valid_i = 1; id_rs1_addr_i = 0;
    step("lu_rd0", 7'b0, 0);
    ex_rd_addr_i = 7; id_rs1_addr_i = 3; id_rs2_addr_i = 7; id_uses_rs2_i = 1;
    step("lu_rs2", 7'b1100100, 0);
    id_uses_rs2_i = 0;
    step("lu_rs2_unused", 7'b0, 0);

    // branches and jumps
    idle(); ex_valid_i = 1; ex_PCSrc_i = 2'b01; ex_br_taken_i = 1; ex_br_addr_i = 32'h100;
    step("br_taken", 7'b0001110, 32'h100);
    ex_br_taken_i = 0;
    step("br_not_taken", 7'b0, 0);
    idle(); ex_valid_i = 1; ex_PCSrc_i = 2'b10; ex_MemRead_i = 1; ex_rd_addr_i = 5;
    id_valid_i = 1; id_rs1_addr_i = 5;
    step("jump_over_lu", 7'b0001110, 32'hDEAD_BEE0);
    idle(); ex_valid_i = 1; ex_PCSrc_i = 2'b11; ex_br_taken_i = 1;
    step("pcsrc_reserved", 7'b0, 0);

    // store held off by the LSU for four cycles; debug request must be ignored meanwhile
    idle(); ex_valid_i = 1; ex_MemWrite_i = 1; lsu_ready_i = 0;
    step("lsu_wait_entry", 7'b1110000, 0);
    dbg_halt_req_i = 1;
    for (int i = 0; i < 3; i++) step("lsu_wait_hold", 7'b1110000, 0);
    lsu_ready_i = 1;
    step("lsu_wait_done", 7'b0, 0);
    idle();
    step("lsu_back_in_run", 7'b0, 0);

    // timeout: four wait cycles, then the access is dropped
    ex_valid_i = 1; ex_MemWrite_i = 1; lsu_ready_i = 0;
    step("to_entry", 7'b1110000, 0);
    for (int i = 0; i < 3; i++) step("to_hold", 7'b1110000, 0);
    step("to_abort", 7'b1100100, 0);
    exp_err = 1'b1;
    idle();
    step("to_err_sticky", 7'b0, 0);

    cnt_clr_i = 1;
    step("cnt_clr", 7'b0, 0);
    cnt_clr_i = 0;
    step("cnt_cleared", 7'b0, 0);

    // debug request loses to an active hazard
    ex_valid_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 9; id_valid_i = 1; id_rs1_addr_i = 9;
    dbg_halt_req_i = 1;
    step("dbg_vs_lu", 7'b1100100, 0);
    idle();
    step("dbg_not_taken", 7'b0, 0);

    // debug halt long enough to saturate the stall counter
    dbg_halt_req_i = 1;
    step("dbg_req", 7'b0, 0);
    dbg_halt_req_i = 0;
    for (int i = 0; i < 18; i++) step("dbg_halted", 7'b1110001, 0);
    dbg_halt_req_i = 1; dbg_resume_i = 1;
    step("dbg_resume_wins", 7'b0, 0);
    idle();
    step("dbg_resumed", 7'b0, 0);

    // reset while halted
    dbg_halt_req_i = 1;
    step("dbg_req2", 7'b0, 0);
    dbg_halt_req_i = 0;
    step("dbg_halted2", 7'b1110001, 0);
    rst = 1;
    step("rst_in_dbg", 7'b0, 0);
    rst = 0;
    step("after_rst", 7'b0, 0);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
